// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencer for the 5-stage core: turns hazard-unit stall/flush decisions,
// memory busy and decoded HALT into stage-register controls, with watchdog and perf counters.
module pipe_stage_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             MemBusy,
  input  logic             Halt_ID,
  output logic             PcWr,
  output logic             IfIdWr,
  output logic             IfIdFlush,
  output logic             IdExBubble,
  output logic             IdExWr,
  output logic             ExMemWr,
  output logic             MemWbWr,
  output logic             Halted,
  output logic             WdErr,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    MEM_WAIT = 3'd2,
    FLUSH    = 3'd3,
    DRAIN    = 3'd4,
    HALTED   = 3'd5
  } state_e;

  localparam logic [2:0]       FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0]       DRAIN_LOAD  = 3'(DRAIN_CYCLES - 1);
  localparam logic [8:0]       MAX_STALL_W = 9'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           nextState_s;
  logic [2:0]       cycCnt_r;
  logic [2:0]       cycCntNext_s;
  logic [8:0]       consec_r;
  logic [CNT_W-1:0] stallCnt_r;
  logic [CNT_W-1:0] flushCnt_r;
  logic             wdErr_r;
  logic             halted_r;

  logic pcWr_s, ifIdWr_s, ifIdFlush_s, idExBubble_s, downWr_s;
  logic stallApplied_s, flushEvent_s, wdTrip_s;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Same-cycle stage controls and next-state decision.
  always_comb begin
    pcWr_s         = 1'b0;
    ifIdWr_s       = 1'b0;
    ifIdFlush_s    = 1'b0;
    idExBubble_s   = 1'b0;
    downWr_s       = 1'b0;
    stallApplied_s = 1'b0;
    flushEvent_s   = 1'b0;
    wdTrip_s       = 1'b0;
    nextState_s    = state_r;
    cycCntNext_s   = cycCnt_r;
    if (RST) begin
      nextState_s  = IDLE;
      cycCntNext_s = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            nextState_s = RUN;
          end else begin
            nextState_s = IDLE;
          end
        end
        RUN: begin
          if (MemBusy) begin
            nextState_s = MEM_WAIT;
          end else if (Flush) begin
            pcWr_s       = 1'b1;
            ifIdFlush_s  = 1'b1;
            idExBubble_s = 1'b1;
            downWr_s     = 1'b1;
            flushEvent_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              nextState_s  = FLUSH;
              cycCntNext_s = FLUSH_LOAD;
            end else begin
              nextState_s = RUN;
            end
          end else if (Stall) begin
            idExBubble_s   = 1'b1;
            downWr_s       = 1'b1;
            stallApplied_s = 1'b1;
            if ((consec_r + 9'd1) > MAX_STALL_W) begin
              wdTrip_s    = 1'b1;
              nextState_s = HALTED;
            end else begin
              nextState_s = RUN;
            end
          end else if (Halt_ID) begin
            idExBubble_s = 1'b1;
            downWr_s     = 1'b1;
            if (DRAIN_CYCLES > 1) begin
              nextState_s  = DRAIN;
              cycCntNext_s = DRAIN_LOAD;
            end else begin
              nextState_s = HALTED;
            end
          end else begin
            pcWr_s   = 1'b1;
            ifIdWr_s = 1'b1;
            downWr_s = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (MemBusy) begin
            nextState_s = MEM_WAIT;
          end else begin
            nextState_s = RUN;
          end
        end
        FLUSH: begin
          if (MemBusy) begin
            nextState_s = FLUSH;
          end else begin
            pcWr_s       = 1'b1;
            ifIdFlush_s  = 1'b1;
            idExBubble_s = 1'b1;
            downWr_s     = 1'b1;
            if (Flush) begin
              flushEvent_s = 1'b1;
              cycCntNext_s = FLUSH_LOAD;
            end else if (cycCnt_r <= 3'd1) begin
              nextState_s  = RUN;
              cycCntNext_s = 3'd0;
            end else begin
              cycCntNext_s = cycCnt_r - 3'd1;
            end
          end
        end
        DRAIN: begin
          if (MemBusy) begin
            nextState_s = DRAIN;
          end else begin
            idExBubble_s = 1'b1;
            downWr_s     = 1'b1;
            if (cycCnt_r <= 3'd1) begin
              nextState_s  = HALTED;
              cycCntNext_s = 3'd0;
            end else begin
              cycCntNext_s = cycCnt_r - 3'd1;
            end
          end
        end
        HALTED: begin
          nextState_s = HALTED;
        end
        default: begin
          nextState_s  = IDLE;
          cycCntNext_s = 3'd0;
        end
      endcase
    end
  end

  // Sequencer state, watchdog and saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      cycCnt_r   <= 3'd0;
      consec_r   <= 9'd0;
      stallCnt_r <= '0;
      flushCnt_r <= '0;
      wdErr_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      cycCnt_r   <= cycCntNext_s;
      consec_r   <= stallApplied_s ? (consec_r + 9'd1) : 9'd0;
      stallCnt_r <= stallApplied_s ? satInc(stallCnt_r) : stallCnt_r;
      flushCnt_r <= flushEvent_s ? satInc(flushCnt_r) : flushCnt_r;
      wdErr_r    <= wdErr_r | wdTrip_s;
      halted_r   <= (nextState_s == HALTED);
    end
  end

  assign PcWr       = pcWr_s;
  assign IfIdWr     = ifIdWr_s;
  assign IfIdFlush  = ifIdFlush_s;
  assign IdExBubble = idExBubble_s;
  assign IdExWr     = downWr_s;
  assign ExMemWr    = downWr_s;
  assign MemWbWr    = downWr_s;
  assign Halted     = halted_r & ~RST;
  assign WdErr      = wdErr_r;
  assign State      = state_r;
  assign StallCnt   = stallCnt_r;
  assign FlushCnt   = flushCnt_r;

endmodule
